ysyx_24110006_axi_sram: RTL and testbench

AXI4 responder (slave) backing a word-addressed on-chip memory; it is the far end of the LSU/IFU master ports. Read channel supports INCR bursts for instruction refill; write channel supports single-beat writes with byte strobes. Sits behind the crossbar/arbiter in simulation and FPGA builds.

---
 rtl/ysyx_24110006_axi_sram.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_ysyx_24110006_axi_sram.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_axi_sram.sv
// AXI4 responder over a word-addressed SRAM: INCR read bursts, single-beat strobed writes.
// Optional SRAM_RAND_DELAY_EN adds LFSR-driven 0-7 cycle response delays.
module ysyx_24110006_axi_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic [1:0]  o_axi_rresp,
  output logic        o_axi_rvalid,
  output logic        o_axi_rlast,
  output logic [3:0]  o_axi_rid,
  input  logic        i_axi_rready,
  input  logic [31:0] i_axi_awaddr,
  input  logic        i_axi_awvalid,
  input  logic [3:0]  i_axi_awid,
  input  logic [7:0]  i_axi_awlen,
  input  logic [2:0]  i_axi_awsize,
  input  logic [1:0]  i_axi_awburst,
  output logic        o_axi_awready,
  input  logic [31:0] i_axi_wdata,
  input  logic [3:0]  i_axi_wstrb,
  input  logic        i_axi_wvalid,
  input  logic        i_axi_wlast,
  output logic        o_axi_wready,
  output logic [1:0]  o_axi_bresp,
  output logic        o_axi_bvalid,
  output logic [3:0]  o_axi_bid,
  input  logic        i_axi_bready
);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem_q [MEM_WORDS];
  logic [2:0]  dly_s;
  logic        unused_s;

  // Size/burst type and sub-word address bits carry no information for this slave.
  assign unused_s = ^{i_axi_arsize, i_axi_arburst, i_axi_awsize, i_axi_awburst,
                      i_axi_araddr[1:0], i_axi_awaddr[1:0]};

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) lfsr_q <= 8'h05;
    else         lfsr_q <= {lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[7:1]};
  end
  assign dly_s = lfsr_q[2:0];
`else
  assign dly_s = 3'd0;
`endif

  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d, rdata_q, rdata_d, ld_addr_s;
  logic [7:0]  r_len_q, r_len_d, r_beat_q, r_beat_d, ld_beat_s;
  logic [2:0]  r_cnt_q, r_cnt_d;
  logic [3:0]  rid_q, rid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d, arready_q, arready_d;
  logic        ar_hs_s, r_hs_s, ld_en_s;

  assign ar_hs_s = i_axi_arvalid && arready_q;
  assign r_hs_s  = rvalid_q && i_axi_rready;

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_hs_s) r_state_d = (dly_s != 3'd0) ? R_WAIT : R_DATA;
              else         r_state_d = R_IDLE;
      R_WAIT: if (r_cnt_q <= 3'd1) r_state_d = R_DATA;
              else                 r_state_d = R_WAIT;
      R_DATA: if (r_hs_s && rlast_q)          r_state_d = R_IDLE;
              else if (r_hs_s && dly_s != 3'd0) r_state_d = R_WAIT;
              else                             r_state_d = R_DATA;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Beat data is fetched one cycle after entering R_DATA, or straight after a beat when no delay is due.
  always_comb begin
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    ld_en_s   = 1'b0;
    ld_addr_s = r_addr_q;
    ld_beat_s = r_beat_q;
    case (r_state_q)
      R_IDLE: if (ar_hs_s) begin
        r_addr_d = {i_axi_araddr[31:2], 2'b00};
        r_len_d  = i_axi_arlen;
        rid_d    = i_axi_arid;
        r_beat_d = 8'd0;
        r_cnt_d  = dly_s;
      end else begin
        r_cnt_d = r_cnt_q;
      end
      R_WAIT: r_cnt_d = (r_cnt_q != 3'd0) ? r_cnt_q - 3'd1 : 3'd0;
      R_DATA: if (!rvalid_q) begin
        ld_en_s = 1'b1;
      end else if (r_hs_s && rlast_q) begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
      end else if (r_hs_s) begin
        r_addr_d  = r_addr_q + 32'd4;
        r_beat_d  = r_beat_q + 8'd1;
        r_cnt_d   = dly_s;
        ld_addr_s = r_addr_d;
        ld_beat_s = r_beat_d;
        ld_en_s   = (dly_s == 3'd0);
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end else begin
        rvalid_d = rvalid_q;
      end
      default: r_cnt_d = 3'd0;
    endcase
    if (ld_en_s) begin
      rvalid_d = 1'b1;
      rlast_d  = (ld_beat_s == r_len_q);
      rdata_d  = addr_ok(ld_addr_s) ? mem_q[addr_idx(ld_addr_s)] : 32'd0;
      rresp_d  = addr_ok(ld_addr_s) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      rdata_d = rdata_d;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  // Read-side state and registered read-channel outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'd0;
      r_len_q   <= 8'd0;
      r_beat_q  <= 8'd0;
      r_cnt_q   <= 3'd0;
      rid_q     <= 4'd0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
    end
  end

  w_state_e    w_state_q, w_state_d;
  logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d, bid_q, bid_d;
  logic [2:0]  w_cnt_q, w_cnt_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d, wbad_len_q, wbad_len_d;
  logic        bvalid_q, bvalid_d, awready_q, awready_d, wready_q, wready_d;
  logic        aw_hs_s, w_hs_s, mem_we_s;

  assign aw_hs_s = i_axi_awvalid && awready_q;
  assign w_hs_s  = i_axi_wvalid && wready_q;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (aw_done_q && w_done_q) w_state_d = (dly_s != 3'd0) ? W_WAIT : W_RESP;
              else                       w_state_d = W_IDLE;
      W_WAIT: if (w_cnt_q <= 3'd1) w_state_d = W_RESP;
              else                 w_state_d = W_WAIT;
      W_RESP: if (bvalid_q && i_axi_bready) w_state_d = W_IDLE;
              else                          w_state_d = W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  // AW and W are captured independently; the commit happens the cycle after both are held.
  always_comb begin
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bid_d      = bid_q;
    w_cnt_d    = w_cnt_q;
    bresp_d    = bresp_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wbad_len_d = wbad_len_q;
    bvalid_d   = bvalid_q;
    mem_we_s   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          waddr_d    = {i_axi_awaddr[31:2], 2'b00};
          bid_d      = i_axi_awid;
          wbad_len_d = (i_axi_awlen != 8'd0);
          aw_done_d  = 1'b1;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (w_hs_s && i_axi_wlast) begin
          wdata_d  = i_axi_wdata;
          wstrb_d  = i_axi_wstrb;
          w_done_d = 1'b1;
        end else begin
          w_done_d = w_done_q;
        end
        if (aw_done_q && w_done_q) begin
          mem_we_s  = addr_ok(waddr_q) && !wbad_len_q;
          bresp_d   = mem_we_s ? RESP_OKAY : RESP_SLVERR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_cnt_d   = dly_s;
          bvalid_d  = (dly_s == 3'd0);
        end else begin
          mem_we_s = 1'b0;
        end
      end
      W_WAIT: begin
        w_cnt_d  = (w_cnt_q != 3'd0) ? w_cnt_q - 3'd1 : 3'd0;
        bvalid_d = (w_cnt_q <= 3'd1);
      end
      W_RESP: if (bvalid_q && i_axi_bready) bvalid_d = 1'b0;
              else                          bvalid_d = bvalid_q;
      default: bvalid_d = 1'b0;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
  end

  // Write-side state and registered write-channel outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      w_state_q  <= W_IDLE;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      bid_q      <= 4'd0;
      w_cnt_q    <= 3'd0;
      bresp_q    <= 2'b00;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wbad_len_q <= 1'b0;
      bvalid_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bid_q      <= bid_d;
      w_cnt_q    <= w_cnt_d;
      bresp_q    <= bresp_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wbad_len_q <= wbad_len_d;
      bvalid_q   <= bvalid_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
    end
  end

  // Byte-lane write port; the array itself is never reset.
  always_ff @(posedge i_clock) begin
    if (mem_we_s && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[addr_idx(waddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign o_axi_arready = arready_q;
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;
  assign o_axi_rvalid  = rvalid_q;
  assign o_axi_rlast   = rlast_q;
  assign o_axi_rid     = rid_q;
  assign o_axi_awready = awready_q;
  assign o_axi_wready  = wready_q;
  assign o_axi_bresp   = bresp_q;
  assign o_axi_bvalid  = bvalid_q;
  assign o_axi_bid     = bid_q;

endmodule

// File: tb/tb_ysyx_24110006_axi_sram.sv
// Randomized bench for ysyx_24110006_axi_sram against a word-level memory model.
`timescale 1ns/1ps
module tb_ysyx_24110006_axi_sram;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]  arid, awid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        o_axi_arready, o_axi_rvalid, o_axi_rlast, o_axi_awready, o_axi_wready, o_axi_bvalid;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp, o_axi_bresp;
  logic [3:0]  o_axi_rid, o_axi_bid;

  always #5 clk = ~clk;

  ysyx_24110006_axi_sram dut (
    .i_clock(clk), .i_reset(rst),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .i_axi_arid(arid), .i_axi_arlen(arlen),
    .i_axi_arsize(arsize), .i_axi_arburst(arburst), .o_axi_arready(o_axi_arready),
    .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rvalid(o_axi_rvalid),
    .o_axi_rlast(o_axi_rlast), .o_axi_rid(o_axi_rid), .i_axi_rready(rready),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .i_axi_awid(awid), .i_axi_awlen(awlen),
    .i_axi_awsize(awsize), .i_axi_awburst(awburst), .o_axi_awready(o_axi_awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .i_axi_wlast(wlast),
    .o_axi_wready(o_axi_wready), .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid),
    .o_axi_bid(o_axi_bid), .i_axi_bready(bready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [int unsigned];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'(WORDS * 4);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (!in_rng(a)) return 32'd0;
    if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] id, input logic [7:0] len, input int w_dly,
                           input int aw_dly, input int hold_b, output logic [1:0] resp);
    logic [31:0] old;
    logic [1:0]  exp_resp;
    int          lat;
    exp_resp = (in_rng(addr) && len == 8'd0) ? 2'b00 : 2'b10;
    fork
      begin
        int t; bit hs;
        repeat (aw_dly) @(negedge clk);
        awaddr = addr; awid = id; awlen = len;
        awsize = 3'($urandom); awburst = 2'($urandom); awvalid = 1'b1;
        hs = 1'b0; t = 0;
        while (!hs && t < 40) begin hs = o_axi_awready; @(negedge clk); t++; end
        awvalid = 1'b0;
        check_val("aw_handshake", 32'(hs), 32'd1);
      end
      begin
        int t; bit hs;
        repeat (w_dly) @(negedge clk);
        for (int b = 0; b <= int'(len); b++) begin
          wdata = (b == int'(len)) ? data : $urandom; wstrb = strb;
          wlast = (b == int'(len)); wvalid = 1'b1;
          hs = 1'b0; t = 0;
          while (!hs && t < 40) begin hs = o_axi_wready; @(negedge clk); t++; end
          check_val("w_handshake", 32'(hs), 32'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
      end
    join
    lat = 0;
    while (!o_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
    check_val("bvalid_seen", 32'(o_axi_bvalid), 32'd1);
`ifdef SRAM_RAND_DELAY_EN
    check_val("b_latency_1to8", 32'(lat >= 1 && lat <= 8), 32'd1);
`else
    check_val("b_latency", 32'(lat), 32'd1);
`endif
    resp = o_axi_bresp;
    check_val("bresp", 32'(o_axi_bresp), 32'(exp_resp));
    check_val("bid", 32'(o_axi_bid), 32'(id));
    repeat (hold_b) begin
      @(negedge clk);
      check_val("bvalid_hold", 32'(o_axi_bvalid), 32'd1);
      check_val("bresp_hold", 32'(o_axi_bresp), 32'(exp_resp));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("bvalid_drop", 32'(o_axi_bvalid), 32'd0);
    @(negedge clk);
    check_val("bvalid_once", 32'(o_axi_bvalid), 32'd0);
    if (exp_resp == 2'b00) begin
      old = ref_mem.exists(widx(addr)) ? ref_mem[widx(addr)] : 32'd0;
      for (int b = 0; b < 4; b++) if (strb[b]) old[8*b +: 8] = data[8*b +: 8];
      ref_mem[widx(addr)] = old;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input bit toggle, output logic [31:0] last_data);
    logic [31:0] a;
    int t, beat;
    bit hs;
    a = {addr[31:2], 2'b00};
    last_data = 32'd0;
    araddr = addr; arid = id; arlen = len;
    arsize = 3'($urandom); arburst = 2'($urandom); arvalid = 1'b1;
    hs = 1'b0; t = 0;
    while (!hs && t < 40) begin hs = o_axi_arready; @(negedge clk); t++; end
    arvalid = 1'b0;
    check_val("ar_handshake", 32'(hs), 32'd1);
    t = 0;
    while (!o_axi_rvalid && t < 20) begin @(negedge clk); t++; end
`ifdef SRAM_RAND_DELAY_EN
    check_val("r_latency_1to8", 32'(t >= 1 && t <= 8), 32'd1);
`else
    check_val("r_latency", 32'(t), 32'd1);
`endif
    beat = 0; t = 0;
    while (beat <= int'(len) && t < 300) begin
      rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_axi_rvalid && rready) begin
        check_val("rdata", o_axi_rdata, model_rd(a));
        check_val("rresp", 32'(o_axi_rresp), in_rng(a) ? 32'd0 : 32'd2);
        check_val("rid", 32'(o_axi_rid), 32'(id));
        check_val("rlast", 32'(o_axi_rlast), 32'(beat == int'(len)));
        check_val("arready_busy", 32'(o_axi_arready), 32'd0);
        last_data = o_axi_rdata;
        a = a + 32'd4;
        beat++;
      end
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    check_val("r_beats", 32'(beat), 32'(int'(len) + 1));
    check_val("rvalid_drop", 32'(o_axi_rvalid), 32'd0);
    check_val("arready_back", 32'(o_axi_arready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  br;
    int t, beats, idx;
    logic [7:0]  len;
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    rready = 1'b0; bready = 1'b0; araddr = 32'd0; awaddr = 32'd0; wdata = 32'd0;
    arid = 4'd0; awid = 4'd0; wstrb = 4'd0; arlen = 8'd0; awlen = 8'd0;
    arsize = 3'd0; awsize = 3'd0; arburst = 2'd0; awburst = 2'd0;
    repeat (2) @(negedge clk);
    check_val("rst_arready", 32'(o_axi_arready), 32'd0);
    check_val("rst_awready", 32'(o_axi_awready), 32'd0);
    check_val("rst_wready", 32'(o_axi_wready), 32'd0);
    check_val("rst_rvalid", 32'(o_axi_rvalid), 32'd0);
    check_val("rst_rlast", 32'(o_axi_rlast), 32'd0);
    check_val("rst_bvalid", 32'(o_axi_bvalid), 32'd0);
    check_val("rst_rdata", o_axi_rdata, 32'd0);
    check_val("rst_rresp", 32'(o_axi_rresp), 32'd0);
    check_val("rst_bresp", 32'(o_axi_bresp), 32'd0);
    check_val("rst_rid", 32'(o_axi_rid), 32'd0);
    check_val("rst_bid", 32'(o_axi_bid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_arready", 32'(o_axi_arready), 32'd1);
    check_val("rel_awready", 32'(o_axi_awready), 32'd1);
    check_val("rel_wready", 32'(o_axi_wready), 32'd1);

    // Fill the words the rest of the run reads, including the last word of the array.
    for (int i = 0; i < 16; i++) axi_write(BASE + 32'(i * 4), $urandom, 4'hF, 4'(i), 8'd0, 0, 0, 0, br);
    axi_write(BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 4'd1, 8'd0, 0, 0, 0, br);

    axi_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 4'd5, 8'd0, 0, 0, 0, br);
    check_val("tp1_bresp", 32'(br), 32'd0);
    axi_read(BASE + 32'h10, 8'd0, 4'd3, 1'b0, rd);
    check_val("tp1_rdata", rd, 32'hDEADBEEF);
    axi_write(BASE + 32'h11, 32'h0000AB00, 4'b0010, 4'd6, 8'd0, 1, 1, 0, br);
    axi_read(BASE + 32'h10, 8'd0, 4'd7, 1'b0, rd);
    check_val("tp2_byte_merge", rd, 32'hDEADABEF);

    axi_write(BASE + 32'h20, 32'h1234_5678, 4'hF, 4'd9, 8'd0, 0, 3, 4, br);
    axi_read(BASE + 32'h20, 8'd0, 4'd9, 1'b0, rd);
    check_val("tp3_w_first", rd, 32'h1234_5678);

    axi_read(BASE, 8'd3, 4'd2, 1'b1, rd);

    axi_read(32'h7FFF_FFFC, 8'd0, 4'd1, 1'b0, rd);
    check_val("tp5_below_rdata", rd, 32'd0);
    axi_read(32'h7FFF_FFFC, 8'd1, 4'd4, 1'b0, rd);
    axi_read(BASE + 32'hFFC, 8'd1, 4'd8, 1'b1, rd);
    axi_write(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 4'd4, 8'd0, 0, 0, 0, br);
    check_val("tp5_above_bresp", 32'(br), 32'd2);
    axi_read(BASE, 8'd0, 4'd4, 1'b0, rd);
    axi_write(BASE + 32'h8, 32'h5555_AAAA, 4'hF, 4'd2, 8'd2, 0, 1, 1, br);
    check_val("awlen_bresp", 32'(br), 32'd2);
    axi_read(BASE + 32'h8, 8'd0, 4'd2, 1'b0, rd);

    // Reset while a long burst is streaming.
    araddr = BASE; arid = 4'hA; arlen = 8'd7; arvalid = 1'b1;
    t = 0;
    while (!o_axi_arready && t < 40) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1; beats = 0; t = 0;
    while (beats < 2 && t < 60) begin if (o_axi_rvalid) beats++; @(negedge clk); t++; end
    rready = 1'b0; t = 0;
    while (!o_axi_rvalid && t < 20) begin @(negedge clk); t++; end
    check_val("mid_rvalid_before", 32'(o_axi_rvalid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rvalid_async", 32'(o_axi_rvalid), 32'd0);
    check_val("mid_rlast_async", 32'(o_axi_rlast), 32'd0);
    check_val("mid_arready_async", 32'(o_axi_arready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_arready_rel", 32'(o_axi_arready), 32'd1);
    axi_read(BASE + 32'h10, 8'd1, 4'hB, 1'b0, rd);

    for (int k = 0; k < 60; k++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        len = 8'd0;
        case ($urandom_range(0, 9))
          0: begin
            axi_write(BASE + 32'h1000 + 32'(idx * 4), $urandom, 4'hF, 4'($urandom), 8'd0,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), br);
          end
          1: begin
            len = 8'($urandom_range(1, 3));
            axi_write(BASE + 32'(idx * 4), $urandom, 4'($urandom), 4'($urandom), len,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), br);
          end
          default: begin
            axi_write(BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), $urandom, 4'($urandom),
                      4'($urandom), 8'd0, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), br);
          end
        endcase
      end else begin
        len = 8'($urandom_range(0, (15 - idx) < 3 ? (15 - idx) : 3));
        axi_read(BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), len, 4'($urandom),
                 1'($urandom_range(0, 1)), rd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
